// File: rtl/datapath_gen2.sv
`default_nettype none
// ============================================================================
// Module   : datapath_gen2
// Purpose  : Parametrised accumulator data path for the edulent CPU. Holds
//            PC, IR, SP, MA, MD, A, AP, R, OUT and flags {V,N,C,Z}, executes
//            one transfer command per cycle and reaches memory through a
//            req/ack handshake so slow memories stall the core.
// Ports    : i_clk, i_rstn (async, active-low)
//            i_xfer_cmd[3:0], i_alu_calc, i_alu_op[3:0], i_alu_dst,
//            i_br_cond[1:0], i_inc_pc, i_sp_op[1:0]   - control unit
//            i_in[DW-1:0] / o_out[DW-1:0]               - I/O ports
//            o_ir[DW-1:0], o_flags[3:0], o_busy         - status to control
//            o_mem_req, o_mem_we, o_mem_addr[AW-1:0],
//            o_mem_wdata[DW-1:0], i_mem_ack,
//            i_mem_rdata[DW-1:0]                        - memory handshake
// Revision : 1.0 - initial release
// ============================================================================
module datapath_gen2 #(
  parameter int            DW     = 8,
  parameter int            AW     = 8,
  parameter logic [AW-1:0] SP_RST = '1
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic [3:0]    i_xfer_cmd,
  input  logic          i_alu_calc,
  input  logic [3:0]    i_alu_op,
  input  logic          i_alu_dst,
  input  logic [1:0]    i_br_cond,
  input  logic          i_inc_pc,
  input  logic [1:0]    i_sp_op,
  input  logic [DW-1:0] i_in,
  output logic [DW-1:0] o_out,
  output logic [DW-1:0] o_ir,
  output logic [3:0]    o_flags,
  output logic          o_busy,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic          i_mem_ack,
  input  logic [DW-1:0] i_mem_rdata
);

  // Transfer command encodings
  localparam logic [3:0] CMD_MA_PC = 4'h1;
  localparam logic [3:0] CMD_READ  = 4'h2;
  localparam logic [3:0] CMD_IR_MD = 4'h3;
  localparam logic [3:0] CMD_MA_MD = 4'h4;
  localparam logic [3:0] CMD_A_MD  = 4'h5;
  localparam logic [3:0] CMD_AP_MD = 4'h6;
  localparam logic [3:0] CMD_MA_AP = 4'h7;
  localparam logic [3:0] CMD_MA_SP = 4'h8;
  localparam logic [3:0] CMD_MD_A  = 4'h9;
  localparam logic [3:0] CMD_MD_AP = 4'hA;
  localparam logic [3:0] CMD_WRITE = 4'hB;
  localparam logic [3:0] CMD_WB_R  = 4'hC;
  localparam logic [3:0] CMD_BR    = 4'hD;
  localparam logic [3:0] CMD_A_IN  = 4'hE;
  localparam logic [3:0] CMD_OUT_A = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, sp_q, sp_d, ma_q, ma_d;
  logic [DW-1:0] ir_q, ir_d, md_q, md_d, a_q, a_d, ap_q, ap_d;
  logic [DW-1:0] r_q, r_d, out_q, out_d;
  logic [3:0]    flags_q, flags_d;   // {V,N,C,Z}

  logic          idle;
  logic [DW:0]   alu_res;            // bit DW carries C (carry/borrow/shift-out)
  logic          alu_v;
  logic          br_taken;

  assign idle = (state_q == ST_IDLE);

  // --------------------------------------------------------------------------
  // Access FSM: commands are only accepted from IDLE, so a stalled access
  // freezes the command stream instead of corrupting MA/MD.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_xfer_cmd == CMD_READ)       state_d = ST_RD;
        else if (i_xfer_cmd == CMD_WRITE) state_d = ST_WR;
      end
      ST_RD, ST_WR: begin
        if (i_mem_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // ALU at DW+1 bits. Shifts are arranged so the shifted-out bit lands in
  // bit DW, letting C be taken from the same place for every operation.
  // --------------------------------------------------------------------------
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (i_alu_op)
      4'h0: alu_res = {1'b0, a_q} + {1'b0, md_q};
      4'h1: alu_res = {1'b0, a_q} + {1'b0, md_q} + {{DW{1'b0}}, flags_q[1]};
      4'h2: alu_res = {1'b0, a_q} - {1'b0, md_q};
      4'h3: alu_res = {1'b0, a_q} - {1'b0, md_q} - {{DW{1'b0}}, flags_q[1]};
      4'h4: alu_res = {1'b0, ~a_q};
      4'h5: alu_res = {1'b0, a_q | md_q};
      4'h6: alu_res = {1'b0, a_q & md_q};
      4'h7: alu_res = {1'b0, a_q ^ md_q};
      4'h8: alu_res = {a_q[0], 1'b0, a_q[DW-1:1]};
      4'h9: alu_res = {a_q, 1'b0};
      4'hA: alu_res = {1'b0, md_q};
      default: alu_res = '0;
    endcase
    // Signed overflow: operands agree (add) / differ (sub) in sign and the
    // result sign differs from A.
    case (i_alu_op)
      4'h0, 4'h1: alu_v = (a_q[DW-1] == md_q[DW-1]) && (alu_res[DW-1] != a_q[DW-1]);
      4'h2, 4'h3: alu_v = (a_q[DW-1] != md_q[DW-1]) && (alu_res[DW-1] != a_q[DW-1]);
      default:    alu_v = 1'b0;
    endcase
  end

  always_comb begin
    case (i_br_cond)
      2'b00:   br_taken = 1'b1;
      2'b01:   br_taken = flags_q[0];
      2'b10:   br_taken = flags_q[1];
      default: br_taken = flags_q[2];
    endcase
  end

  // --------------------------------------------------------------------------
  // Register next-state. Side-band controls (PC inc, SP op, ALU) act even
  // while busy; the command decode comes last so a taken branch overrides
  // the PC increment.
  // --------------------------------------------------------------------------
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    ma_d    = ma_q;
    ir_d    = ir_q;
    md_d    = md_q;
    a_d     = a_q;
    ap_d    = ap_q;
    r_d     = r_q;
    out_d   = out_q;
    flags_d = flags_q;

    if (i_alu_calc) begin
      r_d     = alu_res[DW-1:0];
      flags_d = {alu_v, alu_res[DW-1], alu_res[DW], (alu_res[DW-1:0] == '0)};
    end

    if (i_inc_pc) pc_d = pc_q + AW'(1);

    case (i_sp_op)
      2'b01:   sp_d = sp_q + AW'(1);
      2'b10:   sp_d = sp_q - AW'(1);
      default: sp_d = sp_q;
    endcase

    if ((state_q == ST_RD) && i_mem_ack) md_d = i_mem_rdata;

    if (idle) begin
      case (i_xfer_cmd)
        CMD_MA_PC: ma_d  = pc_q;
        CMD_IR_MD: ir_d  = md_q;
        CMD_MA_MD: ma_d  = AW'(md_q);   // truncates or zero-extends
        CMD_A_MD:  a_d   = md_q;
        CMD_AP_MD: ap_d  = md_q;
        CMD_MA_AP: ma_d  = AW'(ap_q);
        CMD_MA_SP: ma_d  = sp_q;
        CMD_MD_A:  md_d  = a_q;
        CMD_MD_AP: md_d  = ap_q;
        CMD_WB_R: begin
          if (i_alu_dst) ap_d = r_q;
          else           a_d  = r_q;
        end
        CMD_BR:    if (br_taken) pc_d = AW'(md_q);
        CMD_A_IN:  a_d   = i_in;
        CMD_OUT_A: out_d = a_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pc_q    <= '0;
      sp_q    <= SP_RST;
      ma_q    <= '0;
      ir_q    <= '0;
      md_q    <= '0;
      a_q     <= '0;
      ap_q    <= '0;
      r_q     <= '0;
      out_q   <= '0;
      flags_q <= '0;
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      ma_q    <= ma_d;
      ir_q    <= ir_d;
      md_q    <= md_d;
      a_q     <= a_d;
      ap_q    <= ap_d;
      r_q     <= r_d;
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

  assign o_out       = out_q;
  assign o_ir        = ir_q;
  assign o_flags     = flags_q;
  assign o_busy      = !idle;
  assign o_mem_req   = (state_q == ST_RD) || (state_q == ST_WR);
  assign o_mem_we    = (state_q == ST_WR);
  assign o_mem_addr  = ma_q;
  assign o_mem_wdata = md_q;

endmodule
`default_nettype wire

// File: doc/datapath_gen2.md
# datapath_gen2

Second-generation parametrised accumulator data path for the edulent CPU. It holds the architectural registers (PC, IR, SP, MA, MD, A, AP, R, OUT) and the flags C, Z, N, V. It executes one transfer command per cycle from the control unit. Memory is reached through a req/ack handshake with a built-in access FSM, so slow memories stall the core instead of corrupting it.

## Interface
Parameters:
- DW, 8: data width of A, AP, R, MD, IR, OUT, IN.
- AW, 8: address width of PC, SP, MA; MA←MD/AP takes the low AW bits (zero-extended if AW > DW).
- SP_RST, all ones (AW bits): SP reset value.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_xfer_cmd  in  4  transfer command (see Operation).
- i_alu_calc  in  1  latch ALU result into R and update flags.
- i_alu_op  in  4  ALU operation.
- i_alu_dst  in  1  write-back target for cmd C: 0 = A, 1 = AP.
- i_br_cond  in  2  branch condition: 00 always, 01 Z, 10 C, 11 N.
- i_inc_pc  in  1  PC ← PC+1.
- i_sp_op  in  2  01 inc, 10 dec, 00/11 hold.
- i_in  in  DW  input port.
- o_out  out  DW  OUT register.
- o_ir  out  DW  IR register.
- o_flags  out  4  {V,N,C,Z}.
- o_busy  out  1  memory access in progress.
- o_mem_req  out  1  memory request, held until ack.
- o_mem_we  out  1  1 = write.
- o_mem_addr  out  AW  equals MA.
- o_mem_wdata  out  DW  equals MD.
- i_mem_ack  in  1  one-cycle acknowledge; rdata valid in the same cycle.
- i_mem_rdata  in  DW  read data.

## Operation
- Commands:
  - 0 NOP.
  - 1 MA←PC.
  - 2 start read.
  - 3 IR←MD.
  - 4 MA←MD.
  - 5 A←MD.
  - 6 AP←MD.
  - 7 MA←AP.
  - 8 MA←SP.
  - 9 MD←A.
  - A MD←AP.
  - B start write.
  - C R→A/AP per i_alu_dst.
  - D PC←MD if i_br_cond true (flags sampled that cycle).
  - E A←IN.
  - F OUT←A.
- Access FSM states IDLE, RD, WR:
  - IDLE, cmd 2 → RD.
  - IDLE, cmd B → WR.
  - RD/WR assert o_mem_req; o_mem_we = 1 in WR only.
  - On i_mem_ack: RD captures MD←i_mem_rdata; both return to IDLE.
- o_busy = (state ≠ IDLE). While busy, all i_xfer_cmd values are ignored, including 2/B.
- i_inc_pc, i_sp_op and i_alu_calc act regardless of busy.
- ALU ops, computed at DW+1 bits (ops not listed give result 0):
  - 0 ADD A+MD.
  - 1 ADC A+MD+C.
  - 2 SUB A−MD.
  - 3 SBC A−MD−C.
  - 4 NOT ~A.
  - 5 OR.
  - 6 AND.
  - 7 XOR.
  - 8 SHR: C←A[0], MSB←0.
  - 9 SHL: C←A[DW−1].
  - A PASS MD.
- Flags:
  - Z = (result[DW−1:0] == 0).
  - N = result[DW−1].
  - C = bit DW (borrow for SUB/SBC, i.e. A < MD + cin); shift carry for SHR/SHL; 0 for logic/PASS.
  - V = signed overflow for ADD/ADC/SUB/SBC, else 0.
- Conflicts:
  - PC load (cmd 1-type sources: D taken) and i_inc_pc in the same cycle: load wins.
  - A write via cmd 5/C/E and ALU read of A in the same cycle: ALU uses the old A.
- SP, PC and all arithmetic wrap modulo 2^AW / 2^DW.

## Timing
- Reset, asynchronous:
  - PC = MA = 0; SP = SP_RST; all DW registers 0.
  - Flags 0; state IDLE.
  - o_mem_req = o_mem_we = o_busy = 0.
- All register updates take effect at the rising edge where the command is sampled; outputs are registered values.
- Read latency: cmd 2 at edge n → req high from n. Ack at edge m ≥ n+1 → MD valid and busy low after edge m.
- Zero-wait memory (ack in the first req cycle) gives 2 cycles cmd-to-MD.
- ALU: i_alu_calc at edge n → R and flags valid after n. Cmd C may follow at n+1, or the same edge for the old R.
- Reset mid-access drops req immediately; a pending ack is ignored.

## Test plan
- Reset, then read with a 3-cycle ack delay at MA = 0x10 returning 0x5A → req held 3 cycles, MD = 0x5A, busy low after ack, cmd 5 issued while busy is ignored.
- ADD A = 0xFF, MD = 0x01 → R = 0x00, Z = 1, C = 1, V = 0. ADD 0x7F+0x01 → R = 0x80, N = 1, V = 1.
- SUB 0x03−0x05 → R = 0xFE, C = 1, N = 1. SBC with C = 1, 0x05−0x02 → 0x02. SHR 0x81 → 0x40, C = 1.
- Branch cond 01 with Z = 0 plus i_inc_pc → PC+1. Cond 01 with Z = 1, MD = 0x40, plus i_inc_pc → PC = 0x40.
- SP = SP_RST with i_sp_op = 01 → SP wraps to 0; 10 → back to all ones; 11 → hold.
- DW = 16, AW = 12 build: write A = 0xABCD via cmd 9/B at MA = 0xFFF → o_mem_we = 1, wdata 0xABCD, addr 0xFFF.
